// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and arithmetic helpers for mac_stream_cluster
// Purpose: accumulator state encoding, lane-count log2, adder-tree width
// formula and a width-generic saturating/wrapping adder.
// Ports: none (package).
package mac_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_t;

  localparam int DEF_LANES = 8;
  localparam int DEF_DW    = 8;
  localparam int DEF_ACC_W = 32;

  // Widest value sat_add handles; callers extend operands to this width first.
  localparam int SAT_W = 64;

  function automatic int clog2_lanes(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Full product width plus one carry bit per reduction level.
  function automatic int tree_width(input int dw, input int n);
    return 2 * dw + clog2_lanes(n);
  endfunction

  // Adds two SAT_W-bit pre-extended operands and fits the exact sum into a
  // w-bit signed or unsigned range. Returns {overflow, result}; only the low
  // w bits of result are meaningful.
  function automatic logic [SAT_W:0] sat_add(
    input logic [SAT_W-1:0] a,
    input logic [SAT_W-1:0] b,
    input int               w,
    input logic             is_signed,
    input logic             saturate
  );
    logic signed [SAT_W:0] s;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    logic signed [SAT_W:0] one;
    logic                  ovf;
    logic [SAT_W-1:0]      res;
    one = {{SAT_W{1'b0}}, 1'b1};
    s   = $signed({a[SAT_W-1], a}) + $signed({b[SAT_W-1], b});
    if (is_signed) begin
      hi = (one <<< (w - 1)) - one;
      lo = -(one <<< (w - 1));
    end else begin
      hi = (one <<< w) - one;
      lo = '0;
    end
    ovf = (s > hi) || (s < lo);
    if (ovf && saturate) begin
      res = (s > hi) ? hi[SAT_W-1:0] : lo[SAT_W-1:0];
    end else begin
      res = s[SAT_W-1:0];
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// rtl/mac_adder_tree.sv - combinational N-input binary reduction tree
// Purpose: sums N packed IN_W-bit lane values into one OUT_W-bit result.
// Ports:
//   i_data  in   N*IN_W  packed lane values, lane k = bits [k*IN_W +: IN_W]
//   o_sum   out  OUT_W   sum of all lanes (modulo 2^OUT_W)
module mac_adder_tree
  import mac_pkg::*;
#(
  parameter int N      = 8,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 19,
  parameter int SIGNED = 1
) (
  input  logic [N*IN_W-1:0] i_data,
  output logic [OUT_W-1:0]  o_sum
);

  localparam int LVLS = clog2_lanes(N);

  genvar l, k;
  generate
    // Level 0 holds the widened leaves; each later level halves the node count.
    for (l = 0; l <= LVLS; l++) begin : g_lvl
      logic [OUT_W-1:0] w_node [N >> l];
      for (k = 0; k < (N >> l); k++) begin : g_node
        if (l == 0) begin : g_leaf
          wire w_ext = (SIGNED != 0) && i_data[k*IN_W + IN_W - 1];
          assign w_node[k] = {{(OUT_W-IN_W){w_ext}}, i_data[k*IN_W +: IN_W]};
        end else begin : g_add
          assign w_node[k] = g_lvl[l-1].w_node[2*k] + g_lvl[l-1].w_node[2*k+1];
        end
      end
    end
  endgenerate

  assign o_sum = g_lvl[LVLS].w_node[0];

endmodule

// File: rtl/mac_stream_cluster.sv
// rtl/mac_stream_cluster.sv - streaming N-lane dot-product engine with accumulator
// Purpose: multiplies N lane pairs per beat, reduces them in a registered tree
// and accumulates beats until in_last, emitting one result per vector.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-low reset
//   ebl        in   1      global enable, low freezes everything
//   in_valid   in   1      beat present
//   in_ready   out  1      beat accepted this cycle (combinational)
//   in_a/in_b  in   N*DW   packed operands, lane i = bits [i*DW +: DW]
//   in_last    in   1      final beat of the vector
//   out_valid  out  1      result present
//   out_ready  in   1      consumer takes the result
//   out_data   out  ACC_W  dot-product result
//   out_ovf    out  1      overflow seen anywhere in this vector
module mac_stream_cluster
  import mac_pkg::*;
#(
  parameter int N_LANES    = DEF_LANES,
  parameter int DATA_WIDTH = DEF_DW,
  parameter int ACC_WIDTH  = DEF_ACC_W,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ebl,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_LANES*DATA_WIDTH-1:0] in_a,
  input  logic [N_LANES*DATA_WIDTH-1:0] in_b,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_WIDTH-1:0]          out_data,
  output logic                          out_ovf
);

  localparam int VEC_W  = N_LANES * DATA_WIDTH;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int TREE_W = tree_width(DATA_WIDTH, N_LANES);

  logic                      w_stall;

  logic                      r_s0_valid;
  logic                      r_s0_last;
  logic [VEC_W-1:0]          r_s0_a;
  logic [VEC_W-1:0]          r_s0_b;

  logic                      r_s1_valid;
  logic                      r_s1_last;
  logic [N_LANES*PROD_W-1:0] r_s1_prod;

  logic                      r_s2_valid;
  logic                      r_s2_last;
  logic [TREE_W-1:0]         r_s2_sum;

  acc_state_t                r_state;
  logic [ACC_WIDTH-1:0]      r_acc;
  logic                      r_ovf;

  logic                      r_out_valid;
  logic [ACC_WIDTH-1:0]      r_out_data;
  logic                      r_out_ovf;

  assign w_stall   = !ebl || (r_out_valid && !out_ready);
  assign in_ready  = !w_stall;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;

  logic [N_LANES*PROD_W-1:0] w_prod;

  genvar i;
  generate
    for (i = 0; i < N_LANES; i++) begin : g_mul
      wire              w_sa = (SIGNED != 0) && r_s0_a[i*DATA_WIDTH + DATA_WIDTH - 1];
      wire              w_sb = (SIGNED != 0) && r_s0_b[i*DATA_WIDTH + DATA_WIDTH - 1];
      wire [PROD_W-1:0] w_xa = {{DATA_WIDTH{w_sa}}, r_s0_a[i*DATA_WIDTH +: DATA_WIDTH]};
      wire [PROD_W-1:0] w_xb = {{DATA_WIDTH{w_sb}}, r_s0_b[i*DATA_WIDTH +: DATA_WIDTH]};
      // The low 2*DW bits of the product of extended operands are exact in both modes.
      assign w_prod[i*PROD_W +: PROD_W] = w_xa * w_xb;
    end
  endgenerate

  logic [TREE_W-1:0] w_tree_sum;

  mac_adder_tree #(
    .N      (N_LANES),
    .IN_W   (PROD_W),
    .OUT_W  (TREE_W),
    .SIGNED (SIGNED)
  ) u_tree (
    .i_data (r_s1_prod),
    .o_sum  (w_tree_sum)
  );

  logic [ACC_WIDTH-1:0] w_acc_in;
  logic [SAT_W-1:0]     w_acc_ext;
  logic [SAT_W-1:0]     w_sum_ext;
  logic [SAT_W:0]       w_add;
  logic                 w_hold;
  logic [ACC_WIDTH-1:0] w_next;
  logic                 w_next_ovf;

  assign w_acc_in  = (r_state == ACCUM) ? r_acc : '0;
  assign w_acc_ext = {{(SAT_W-ACC_WIDTH){(SIGNED != 0) && w_acc_in[ACC_WIDTH-1]}}, w_acc_in};
  assign w_sum_ext = {{(SAT_W-TREE_W){(SIGNED != 0) && r_s2_sum[TREE_W-1]}}, r_s2_sum};
  assign w_add     = sat_add(w_acc_ext, w_sum_ext, ACC_WIDTH, SIGNED != 0, SATURATE != 0);

  // Once clamped, the accumulator stays on the rail for the rest of the vector.
  assign w_hold     = (SATURATE != 0) && r_ovf;
  assign w_next     = w_hold ? w_acc_in : w_add[ACC_WIDTH-1:0];
  assign w_next_ovf = r_ovf || w_add[SAT_W];

  wire w_unused = &{1'b0, w_add[SAT_W-1:ACC_WIDTH]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s0_valid  <= 1'b0;
      r_s0_last   <= 1'b0;
      r_s0_a      <= '0;
      r_s0_b      <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_prod   <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_last   <= 1'b0;
      r_s2_sum    <= '0;
      r_state     <= IDLE;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else if (!w_stall) begin
      r_s0_valid <= in_valid;
      r_s0_last  <= in_last;
      r_s0_a     <= in_a;
      r_s0_b     <= in_b;

      r_s1_valid <= r_s0_valid;
      r_s1_last  <= r_s0_last;
      r_s1_prod  <= w_prod;

      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_sum   <= w_tree_sum;

      // Not stalled means the output slot is empty or being taken this edge.
      r_out_valid <= 1'b0;
      if (r_s2_valid) begin
        if (r_s2_last) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_next;
          r_out_ovf   <= w_next_ovf;
          r_acc       <= '0;
          r_ovf       <= 1'b0;
          r_state     <= IDLE;
        end else begin
          r_acc   <= w_next;
          r_ovf   <= w_next_ovf;
          r_state <= ACCUM;
        end
      end
    end
  end

endmodule
